// File: rtl/conv_addr_pkg.sv
// Shared types and elaboration helpers for the convolution-window address generator.
package conv_addr_pkg;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_RUN,
      ST_DONE
   } state_e;

   // Bits needed to hold 0..n-1 (at least one bit).
   function automatic int unsigned cnt_w(input int unsigned n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

   // Output dimension of a padded, strided convolution.
   function automatic int unsigned out_dim(input int unsigned img, input int unsigned pad,
                                           input int unsigned k, input int unsigned stride);
      return (img + 2 * pad - k) / stride + 1;
   endfunction

endpackage

// File: rtl/wrap_counter.sv
// Modulo-MAX counter for one loop level; carry flags the wrap back to zero.
module wrap_counter
   import conv_addr_pkg::*;
#(
   parameter int unsigned MAX = 2,
   localparam int unsigned W = cnt_w(MAX)
) (
   input  logic clk,
   input  logic reset,
   input  logic clear,
   input  logic inc,
   output logic wrap_c,
   output logic last_c
);

   logic [W-1:0] count;
   logic [W-1:0] count_nxt;

   always_comb begin
      wrap_c    = inc && (count == W'(MAX - 1));
      count_nxt = count;
      if (clear) begin
         count_nxt = '0;
      end else if (inc) begin
         count_nxt = wrap_c ? '0 : count + W'(1);
      end
      // Looks ahead: the value being loaded is this level's final index.
      last_c = (count_nxt == W'(MAX - 1));
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         count <= '0;
      end else begin
         count <= count_nxt;
      end
   end

endmodule

// File: rtl/conv_window_addr_gen.sv
// Walks every output pixel, channel and kernel tap, streaming one feature-memory
// address per tap; pointers advance with adders only.
module conv_window_addr_gen
   import conv_addr_pkg::*;
#(
   parameter int unsigned IMG_W  = 640,
   parameter int unsigned IMG_H  = 640,
   parameter int unsigned CH     = 3,
   parameter int unsigned K      = 3,
   parameter int unsigned STRIDE = 1,
   parameter int unsigned PAD    = 1,
   parameter int unsigned ADDR_W = 25
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   input  logic [ADDR_W-1:0] base_addr,
   output logic              addr_valid,
   input  logic              addr_ready,
   output logic [ADDR_W-1:0] addr,
   output logic              addr_pad,
   output logic              win_first,
   output logic              win_last,
   output logic              busy,
   output logic              done
);

   localparam int unsigned OUT_W = out_dim(IMG_W, PAD, K, STRIDE);
   localparam int unsigned OUT_H = out_dim(IMG_H, PAD, K, STRIDE);
   localparam int unsigned IDX_W = cnt_w(IMG_W + IMG_H + 4 * K + 8) + 2;

   localparam logic signed [IDX_W-1:0] ONE_S    = IDX_W'(1);
   localparam logic signed [IDX_W-1:0] PAD_S    = IDX_W'(PAD);
   localparam logic signed [IDX_W-1:0] STRIDE_S = IDX_W'(STRIDE);
   localparam logic signed [IDX_W-1:0] IMG_W_S  = IDX_W'(IMG_W);
   localparam logic signed [IDX_W-1:0] IMG_H_S  = IDX_W'(IMG_H);

   localparam logic [ADDR_W-1:0] ROW_STEP   = ADDR_W'(IMG_W);
   localparam logic [ADDR_W-1:0] PLANE_STEP = ADDR_W'(IMG_W * IMG_H);
   localparam logic [ADDR_W-1:0] WIN_STEP   = ADDR_W'(STRIDE);
   localparam logic [ADDR_W-1:0] WROW_STEP  = ADDR_W'(STRIDE * IMG_W);
   localparam logic [ADDR_W-1:0] ORIGIN_OFS = ADDR_W'(PAD * IMG_W + PAD);

   if (PAD >= K || IMG_W + 2 * PAD < K || IMG_H + 2 * PAD < K) begin : g_bad_params
      $error("conv_window_addr_gen: illegal PAD/K/IMG_W/IMG_H combination");
   end

   state_e state_q, state_d;
   logic   load, adv, final_q;
   logic   wrap_kx, wrap_ky, wrap_ch, wrap_ox, wrap_oy;
   logic   last_kx, last_ky, last_ch, last_ox, last_oy;
   logic   pad_n, first_n, last_n, final_n;

   logic signed [IDX_W-1:0] ix_q, iy_q, oxb_q, oyb_q;
   logic signed [IDX_W-1:0] ix_n, iy_n, oxb_n, oyb_n;
   logic [ADDR_W-1:0] orow_q, win_q, plane_q, row_q, tap_q;
   logic [ADDR_W-1:0] orow_n, win_n, plane_n, row_n, tap_n;

   wrap_counter #(.MAX(K))     u_kx (.clk(clk), .reset(reset), .clear(load), .inc(adv),
                                     .wrap_c(wrap_kx), .last_c(last_kx));
   wrap_counter #(.MAX(K))     u_ky (.clk(clk), .reset(reset), .clear(load), .inc(wrap_kx),
                                     .wrap_c(wrap_ky), .last_c(last_ky));
   wrap_counter #(.MAX(CH))    u_ch (.clk(clk), .reset(reset), .clear(load), .inc(wrap_ky),
                                     .wrap_c(wrap_ch), .last_c(last_ch));
   wrap_counter #(.MAX(OUT_W)) u_ox (.clk(clk), .reset(reset), .clear(load), .inc(wrap_ch),
                                     .wrap_c(wrap_ox), .last_c(last_ox));
   wrap_counter #(.MAX(OUT_H)) u_oy (.clk(clk), .reset(reset), .clear(load), .inc(wrap_ox),
                                     .wrap_c(wrap_oy), .last_c(last_oy));

   // Next state plus walk-control strobes.
   always_comb begin
      state_d = state_q;
      load    = 1'b0;
      adv     = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (start) begin
               state_d = ST_RUN;
               load    = 1'b1;
            end
         end
         ST_RUN: begin
            if (addr_valid && addr_ready) begin
               adv = 1'b1;
               if (final_q) state_d = ST_DONE;
            end
         end
         ST_DONE: state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
   end

   // Pointer update: the innermost non-wrapping level decides which origin reloads.
   always_comb begin
      ix_n    = ix_q;
      iy_n    = iy_q;
      oxb_n   = oxb_q;
      oyb_n   = oyb_q;
      orow_n  = orow_q;
      win_n   = win_q;
      plane_n = plane_q;
      row_n   = row_q;
      tap_n   = tap_q;
      if (load) begin
         ix_n    = -PAD_S;
         iy_n    = -PAD_S;
         oxb_n   = -PAD_S;
         oyb_n   = -PAD_S;
         orow_n  = base_addr - ORIGIN_OFS;
         win_n   = orow_n;
         plane_n = orow_n;
         row_n   = orow_n;
         tap_n   = orow_n;
      end else if (adv) begin
         if (!wrap_kx) begin
            ix_n  = ix_q + ONE_S;
            tap_n = tap_q + ADDR_W'(1);
         end else if (!wrap_ky) begin
            ix_n  = oxb_q;
            iy_n  = iy_q + ONE_S;
            row_n = row_q + ROW_STEP;
            tap_n = row_n;
         end else if (!wrap_ch) begin
            ix_n    = oxb_q;
            iy_n    = oyb_q;
            plane_n = plane_q + PLANE_STEP;
            row_n   = plane_n;
            tap_n   = plane_n;
         end else if (!wrap_ox) begin
            oxb_n   = oxb_q + STRIDE_S;
            ix_n    = oxb_n;
            iy_n    = oyb_q;
            win_n   = win_q + WIN_STEP;
            plane_n = win_n;
            row_n   = win_n;
            tap_n   = win_n;
         end else if (!wrap_oy) begin
            oxb_n   = -PAD_S;
            ix_n    = oxb_n;
            oyb_n   = oyb_q + STRIDE_S;
            iy_n    = oyb_n;
            orow_n  = orow_q + WROW_STEP;
            win_n   = orow_n;
            plane_n = orow_n;
            row_n   = orow_n;
            tap_n   = orow_n;
         end
      end
      pad_n   = ix_n[IDX_W-1] || iy_n[IDX_W-1] || (ix_n >= IMG_W_S) || (iy_n >= IMG_H_S);
      first_n = load || wrap_ch;
      last_n  = last_kx && last_ky && last_ch;
      final_n = last_n && last_ox && last_oy;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q    <= ST_IDLE;
         busy       <= 1'b0;
         addr_valid <= 1'b0;
         done       <= 1'b0;
         addr       <= '0;
         addr_pad   <= 1'b0;
         win_first  <= 1'b0;
         win_last   <= 1'b0;
         final_q    <= 1'b0;
         ix_q       <= '0;
         iy_q       <= '0;
         oxb_q      <= '0;
         oyb_q      <= '0;
         orow_q     <= '0;
         win_q      <= '0;
         plane_q    <= '0;
         row_q      <= '0;
         tap_q      <= '0;
      end else begin
         state_q    <= state_d;
         busy       <= (state_d == ST_RUN);
         addr_valid <= (state_d == ST_RUN);
         done       <= (state_d == ST_DONE);
         if (load || adv) begin
            ix_q    <= ix_n;
            iy_q    <= iy_n;
            oxb_q   <= oxb_n;
            oyb_q   <= oyb_n;
            orow_q  <= orow_n;
            win_q   <= win_n;
            plane_q <= plane_n;
            row_q   <= row_n;
            tap_q   <= tap_n;
         end
         // The presented beat only changes on start or a non-final acceptance.
         if (load || (adv && !final_q)) begin
            addr      <= pad_n ? '0 : tap_n;
            addr_pad  <= pad_n;
            win_first <= first_n;
            win_last  <= last_n;
            final_q   <= final_n;
         end
      end
   end

endmodule

// File: tb/tb_conv_window_addr_gen.sv
// Bench: three generator configurations run side by side against a nested-loop reference.
module tb_conv_window_addr_gen;

   localparam int AW   = 25;
   localparam int NDUT = 3;
   localparam int MAXB = 200;

   typedef struct packed {
      logic [AW-1:0] addr;
      logic          pad;
      logic          first;
      logic          last;
   } beat_t;

   typedef struct {
      int            d;
      int            idx;
      logic [AW-1:0] addr;
      logic          pad;
      logic          first;
      logic          last;
   } vec_t;

   logic          clk = 1'b0;
   logic          reset;
   logic          start;
   logic          addr_ready;
   logic [AW-1:0] base       [NDUT];
   logic [AW-1:0] addr       [NDUT];
   logic          addr_valid [NDUT];
   logic          addr_pad   [NDUT];
   logic          win_first  [NDUT];
   logic          win_last   [NDUT];
   logic          busy       [NDUT];
   logic          done       [NDUT];

   int cfg_w [NDUT] = '{4, 5, 4};
   int cfg_h [NDUT] = '{4, 5, 4};
   int cfg_c [NDUT] = '{1, 2, 1};
   int cfg_k [NDUT] = '{3, 3, 1};
   int cfg_s [NDUT] = '{1, 2, 1};
   int cfg_p [NDUT] = '{1, 0, 0};

   beat_t exp_b [NDUT][MAXB];
   beat_t got_b [NDUT][MAXB];
   int    exp_n [NDUT];
   int    got_n [NDUT];
   int    done_cnt [NDUT];
   vec_t  tbl [15];

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   conv_window_addr_gen #(.IMG_W(4), .IMG_H(4), .CH(1), .K(3), .STRIDE(1), .PAD(1), .ADDR_W(AW)) dut_a (
      .clk(clk), .reset(reset), .start(start), .base_addr(base[0]), .addr_valid(addr_valid[0]),
      .addr_ready(addr_ready), .addr(addr[0]), .addr_pad(addr_pad[0]), .win_first(win_first[0]),
      .win_last(win_last[0]), .busy(busy[0]), .done(done[0]));

   conv_window_addr_gen #(.IMG_W(5), .IMG_H(5), .CH(2), .K(3), .STRIDE(2), .PAD(0), .ADDR_W(AW)) dut_b (
      .clk(clk), .reset(reset), .start(start), .base_addr(base[1]), .addr_valid(addr_valid[1]),
      .addr_ready(addr_ready), .addr(addr[1]), .addr_pad(addr_pad[1]), .win_first(win_first[1]),
      .win_last(win_last[1]), .busy(busy[1]), .done(done[1]));

   conv_window_addr_gen #(.IMG_W(4), .IMG_H(4), .CH(1), .K(1), .STRIDE(1), .PAD(0), .ADDR_W(AW)) dut_c (
      .clk(clk), .reset(reset), .start(start), .base_addr(base[2]), .addr_valid(addr_valid[2]),
      .addr_ready(addr_ready), .addr(addr[2]), .addr_pad(addr_pad[2]), .win_first(win_first[2]),
      .win_last(win_last[2]), .busy(busy[2]), .done(done[2]));

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp_v);
      checks++;
      if (act !== exp_v) begin
         errors++;
         $display("FAIL %s: got %0h, expected %0h", nm, act, exp_v);
      end
   endtask

   // Reference: the loop nest written out with plain index arithmetic.
   task automatic build_model(input int d, input logic [AW-1:0] b);
      int    w, h, k, s, p, ow, oh, n, iy, ix;
      beat_t bt;
      w  = cfg_w[d]; h = cfg_h[d]; k = cfg_k[d]; s = cfg_s[d]; p = cfg_p[d];
      ow = (w + 2 * p - k) / s + 1;
      oh = (h + 2 * p - k) / s + 1;
      n  = 0;
      for (int oy = 0; oy < oh; oy++)
         for (int ox = 0; ox < ow; ox++)
            for (int c = 0; c < cfg_c[d]; c++)
               for (int ky = 0; ky < k; ky++)
                  for (int kx = 0; kx < k; kx++) begin
                     iy       = oy * s + ky - p;
                     ix       = ox * s + kx - p;
                     bt.pad   = (iy < 0) || (iy >= h) || (ix < 0) || (ix >= w);
                     bt.addr  = bt.pad ? '0 : AW'(b + (c * h + iy) * w + ix);
                     bt.first = (c == 0) && (ky == 0) && (kx == 0);
                     bt.last  = (c == cfg_c[d] - 1) && (ky == k - 1) && (kx == k - 1);
                     if (n < MAXB) exp_b[d][n] = bt;
                     n++;
                  end
      exp_n[d] = n;
   endtask

   function automatic beat_t cur_beat(input int d);
      beat_t bt;
      bt.addr  = addr[d];
      bt.pad   = addr_pad[d];
      bt.first = win_first[d];
      bt.last  = win_last[d];
      return bt;
   endfunction

   task automatic chk_idle_zero(input string tag);
      for (int d = 0; d < NDUT; d++) begin
         chk($sformatf("%s_dut%0d_outs", tag, d),
             {addr_valid[d], busy[d], done[d], addr_pad[d], win_first[d], win_last[d], addr[d]}, '0);
      end
   endtask

   // Starts all three walks, records accepted beats, checks stalls/done, then compares to model.
   task automatic run_walk(input bit rnd, input bit pokes);
      bit    stall [NDUT];
      beat_t prevb [NDUT];
      beat_t curb  [NDUT];
      int    cyc, extra;
      bit    all_done;
      for (int d = 0; d < NDUT; d++) begin
         build_model(d, base[d]);
         got_n[d] = 0; done_cnt[d] = 0; stall[d] = 1'b0;
      end
      start = 1'b1; addr_ready = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      for (int d = 0; d < NDUT; d++) begin
         chk($sformatf("start_dut%0d_valid_busy", d), {addr_valid[d], busy[d]}, 2'b11);
      end
      cyc = 0; extra = 0;
      while (extra < 3 && cyc < 3000) begin
         start    = 1'b0;
         all_done = 1'b1;
         for (int d = 0; d < NDUT; d++) begin
            curb[d] = cur_beat(d);
            if (stall[d]) begin
               chk($sformatf("stall_dut%0d_valid", d), addr_valid[d], 1'b1);
               chk($sformatf("stall_dut%0d_hold", d), curb[d], prevb[d]);
            end
            if (done[d]) begin
               done_cnt[d]++;
               if (done_cnt[d] == 1) begin
                  chk($sformatf("done_dut%0d_valid_busy", d), {addr_valid[d], busy[d]}, 2'b00);
                  chk($sformatf("done_dut%0d_accepted", d), got_n[d], exp_n[d]);
               end
            end
            if (done_cnt[d] == 0) all_done = 1'b0;
         end
         if (pokes && (cyc == 10 || done[2])) start = 1'b1;
         addr_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
         for (int d = 0; d < NDUT; d++) begin
            if (addr_valid[d] && addr_ready) begin
               if (got_n[d] < MAXB) got_b[d][got_n[d]] = curb[d];
               got_n[d]++;
            end
            stall[d] = addr_valid[d] && !addr_ready;
            prevb[d] = curb[d];
         end
         if (all_done) extra++;
         cyc++;
         @(posedge clk); #1;
      end
      start = 1'b0;
      if (cyc >= 3000) begin
         checks++; errors++;
         $display("FAIL walk_timeout: got %0d cycles, expected under 3000", cyc);
      end
      for (int d = 0; d < NDUT; d++) begin
         chk($sformatf("dut%0d_beat_count", d), got_n[d], exp_n[d]);
         chk($sformatf("dut%0d_done_pulses", d), done_cnt[d], 1);
         for (int i = 0; i < exp_n[d] && i < got_n[d] && i < MAXB; i++) begin
            chk($sformatf("dut%0d_beat%0d", d, i), got_b[d][i], exp_b[d][i]);
         end
      end
   endtask

   initial begin
      int npad;

      tbl[0]  = '{0, 0,  25'd0,        1'b1, 1'b1, 1'b0};
      tbl[1]  = '{0, 4,  25'd100,      1'b0, 1'b0, 1'b0};
      tbl[2]  = '{0, 8,  25'd105,      1'b0, 1'b0, 1'b1};
      tbl[3]  = '{0, 9,  25'd0,        1'b1, 1'b1, 1'b0};
      tbl[4]  = '{0, 13, 25'd101,      1'b0, 1'b0, 1'b0};
      tbl[5]  = '{1, 18, 25'd2,        1'b0, 1'b1, 1'b0};
      tbl[6]  = '{1, 9,  25'd25,       1'b0, 1'b0, 1'b0};
      tbl[7]  = '{1, 17, 25'd37,       1'b0, 1'b0, 1'b1};
      tbl[8]  = '{1, 36, 25'd10,       1'b0, 1'b1, 1'b0};
      tbl[9]  = '{1, 71, 25'd49,       1'b0, 1'b0, 1'b1};
      tbl[10] = '{2, 0,  25'h1FFFFFE,  1'b0, 1'b1, 1'b1};
      tbl[11] = '{2, 1,  25'h1FFFFFF,  1'b0, 1'b1, 1'b1};
      tbl[12] = '{2, 2,  25'h0000000,  1'b0, 1'b1, 1'b1};
      tbl[13] = '{2, 3,  25'h0000001,  1'b0, 1'b1, 1'b1};
      tbl[14] = '{2, 15, 25'h000000D,  1'b0, 1'b1, 1'b1};

      reset = 1'b1; start = 1'b0; addr_ready = 1'b0;
      for (int d = 0; d < NDUT; d++) base[d] = '0;
      repeat (2) @(posedge clk);
      #1;
      chk_idle_zero("in_reset");
      @(negedge clk);
      reset = 1'b0;
      @(posedge clk); #1;
      chk_idle_zero("after_reset");

      // Continuous ready, with start poked mid-walk and in dut C's DONE cycle.
      base[0] = 25'd100; base[1] = 25'd0; base[2] = 25'h1FFFFFE;
      run_walk(1'b0, 1'b1);
      for (int i = 0; i < 15; i++) begin
         chk($sformatf("vec%0d_dut%0d_beat%0d", i, tbl[i].d, tbl[i].idx),
             got_b[tbl[i].d][tbl[i].idx],
             {tbl[i].addr, tbl[i].pad, tbl[i].first, tbl[i].last});
      end
      npad = 0;
      for (int i = 0; i < got_n[1] && i < MAXB; i++) if (got_b[1][i].pad) npad++;
      chk("dut1_pad_beats", npad, 0);

      // Random backpressure with random bases.
      for (int d = 0; d < NDUT; d++) base[d] = AW'($urandom);
      run_walk(1'b1, 1'b0);

      // Asynchronous reset at beat 37 of dut A, then a clean restart.
      base[0] = 25'd100; base[1] = 25'd0; base[2] = 25'h1FFFFFE;
      for (int d = 0; d < NDUT; d++) build_model(d, base[d]);
      addr_ready = 1'b1; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      repeat (37) @(posedge clk);
      #1;
      chk("pre_reset_beat37", cur_beat(0), exp_b[0][37]);
      reset = 1'b1;
      #1;
      chk_idle_zero("async_reset");
      @(negedge clk);
      reset = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      for (int d = 0; d < NDUT; d++) begin
         chk($sformatf("post_reset_dut%0d_quiet", d), {addr_valid[d], busy[d], done[d]}, 3'b000);
      end
      run_walk(1'b0, 1'b0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/conv_window_addr_gen.md
# conv_window_addr_gen

Parametrised convolution-window address generator for the CBS (conv-BN-SiLU) datapath. It walks every output pixel of a feature map and emits one feature-memory address per kernel tap, for every channel. It replaces the fixed 640×640 / 3×3 / stride-1 counter-FSM-adder chain with configurable image size, channel count, kernel size, stride and zero padding. Addresses are delivered on a valid/ready stream to the line-buffer/memory reader; a start/done handshake connects it to the layer sequencer.

## Interface
- IMG_W, 640, input feature-map width in pixels
- IMG_H, 640, input feature-map height in pixels
- CH, 3, input channels (planar layout, channel-major)
- K, 3, square kernel size (1..7)
- STRIDE, 1, window stride (1..4)
- PAD, 1, zero-padding on each border (0..K-1)
- ADDR_W, 25, address width
- clk  in  1  single clock, rising edge
- reset  in  1  asynchronous, active-high; clears all state
- start  in  1  pulse; begins a layer walk when idle
- base_addr  in  ADDR_W  feature-map base; sampled on accepted start
- addr_valid  out  1  address beat available
- addr_ready  in  1  consumer accepts beat when high with addr_valid
- addr  out  ADDR_W  feature address; 0 on padded taps
- addr_pad  out  1  tap lies in padding (consumer substitutes zero)
- win_first  out  1  first beat of an output pixel's window
- win_last  out  1  last beat of an output pixel's window
- busy  out  1  walk in progress
- done  out  1  one-cycle pulse after the final beat is accepted

## Operation
- OUT_W = (IMG_W + 2·PAD − K)/STRIDE + 1; OUT_H likewise (integer division).
- Loop order, outermost first: oy, ox, c, ky, kx. kx fastest.
- iy = oy·STRIDE + ky − PAD; ix = ox·STRIDE + kx − PAD (signed).
- In-bounds tap: addr = base + (c·IMG_H + iy)·IMG_W + ix, modulo 2^ADDR_W; addr_pad = 0.
- Out-of-bounds tap (iy or ix < 0, or ≥ IMG_H/IMG_W): addr = 0, addr_pad = 1. The beat is still emitted.
- win_first asserts when c=0, ky=0, kx=0. win_last asserts when c=CH−1, ky=K−1, kx=K−1.
- Total beats per walk = OUT_H·OUT_W·CH·K·K.
- Address is built incrementally from registered row/plane pointers with adders only. No run-time multipliers.
- FSM states:
  - IDLE: start=1 → RUN; base latched, all counters zeroed.
  - RUN: stays in RUN while beats remain. On acceptance of the final beat → DONE.
  - DONE: done=1 for one cycle, then → IDLE unconditionally.
- start is ignored in RUN and DONE; it has no queued effect.

## Timing
- Reset values: addr_valid=0, addr=0, addr_pad=0, win_first=0, win_last=0, busy=0, done=0, FSM=IDLE.
- All outputs are registered.
- start sampled at edge n in IDLE → busy=1 and addr_valid=1 with beat 0 after edge n.
- Beat held stable (addr, pad, win flags) while addr_valid=1 and addr_ready=0.
- Acceptance at edge m → next beat presented after edge m. This gives one beat per cycle under continuous ready, with no bubbles across window, row or channel boundaries.
- Final beat accepted at edge m → after edge m: addr_valid=0, done=1, busy=0. After edge m+1: done=0.
- reset asserted mid-walk: outputs go to reset values immediately (asynchronous). Nothing is emitted until a new start.
- addr_ready while addr_valid=0 has no effect.

## Structure
- Package conv_addr_pkg:
  - FSM state enum (IDLE, RUN, DONE)
  - constant functions for OUT_W/OUT_H and counter widths ($clog2)
- Sub-module wrap_counter (parameter MAX): increment-enable in, count out, carry/wrap flag out. Five instances are chained kx→ky→c→ox→oy, and the carry chain is gated by acceptance.
- Parameter legality (PAD<K, OUT_W≥1) is checked with an elaboration-time assertion.

## Test plan
- IMG 4×4, CH=1, K=3, S=1, PAD=1, base=100, ready=1:
  - 144 beats emitted; beat 0 has pad=1, addr=0, win_first=1.
  - Beat 4 (ky=1, kx=1) has addr=100, pad=0.
  - Beat 8 has win_last=1; done pulses once after beat 143.
- IMG 5×5, CH=2, K=3, S=2, PAD=0, base=0:
  - OUT 2×2, 72 beats.
  - Window 2 (ox=1) first addr=2.
  - Channel-1 first tap of window 0 addr=25; no pad beats.
- Random addr_ready (50%):
  - Sequence identical to the ready=1 run.
  - Beats stable while stalled; no beat lost or duplicated.
- start pulsed during RUN and in the DONE cycle → ignored; beat count unchanged; single done.
- reset asserted at beat 37 → outputs reset same cycle; new start restarts at beat 0 with pad/addr as in the first scenario.
- base=2^25−2, IMG 4×4, PAD=0, K=1 → beats 0..3 have addr 0x1FFFFFE, 0x1FFFFFF, 0x0000000, 0x0000001.
